cpu_bus_arbiter: RTL
====================

# cpu_bus_arbiter

Round-robin arbiter that shares the CPU's data/address bus control fields (MID, SID, AMID and the MID/SID enables) between several bus masters. Requesters include the control unit, a DMA engine and port service logic. It sits between those requesters and the MID/SID/AMID decoders. Each cycle, exactly one granted requester drives a single data-bus transfer. A lock input allows bounded multi-beat ownership.

## Interface
- NREQ, 4, number of requesters; supported range 2..8.
- MAX_HOLD, 8, maximum consecutive beats one owner may keep the bus while locked; must be at least 1.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester bus request, level-sensitive.
- lock  in  NREQ  per-requester request to keep ownership after the current beat.
- cmd  in  NREQ*12  per-requester command; slice i is {mid[4:0], sid[4:0], amid[1:0]}, with requester i at bits [12i+11:12i].
- gnt  out  NREQ  one-hot or zero registered grant.
- bus_mid  out  5  MID field to the decoder.
- bus_sid  out  5  SID field to the decoder.
- bus_amid  out  2  AMID field to the decoder.
- mid_en  out  1  enables the MID decoder.
- sid_en  out  1  enables the SID decoder.
- owner  out  3  index of the granted requester; only meaningful while |gnt.
- timeout  out  1  one-cycle pulse marking a forced release at MAX_HOLD.

## Operation
- **States.**
  - IDLE: gnt = 0.
  - OWN(i): gnt = 1<<i.
  - Held in a registered gnt vector, a hold_cnt counter of $clog2(MAX_HOLD)+1 bits, and a round-robin pointer rr_ptr.
- **Beat.** A beat occurs in any cycle where gnt[i] && req[i].
  - bus_mid, bus_sid and bus_amid equal cmd slice i, combinationally.
  - mid_en = sid_en = 1.
  - Otherwise the fields are 0 and mid_en = sid_en = 0. AMID 0 selects the PC as address master.
- **Arbitration.**
  - Evaluated every cycle; the result is registered into gnt at the next edge.
  - Candidates are req, with the current owner masked if a forced release is occurring.
  - The winner is the first set candidate searching from rr_ptr upward, with wrap-around modulo NREQ.
  - On each new grant to i, rr_ptr becomes (i+1) mod NREQ.
- **Keep rule.** Owner i retains the grant, with rr_ptr unchanged, when all of the following hold:
  - req[i] = 1,
  - lock[i] = 1,
  - hold_cnt < MAX_HOLD-1.
- **Beat counting.**
  - hold_cnt increments on each beat that is kept.
  - hold_cnt clears to 0 on every new grant and in IDLE.
- **Forced release.** Occurs when owner i has lock[i] = 1, req[i] = 1 and hold_cnt = MAX_HOLD-1.
  - The grant moves to the round-robin winner with i masked.
  - If no other requester is active, the next state is IDLE for one cycle.
  - timeout pulses in the cycle after the final beat.
- **Release.**
  - An unlocked owner, or one whose req has dropped, is released after its current cycle and normal arbitration applies.
  - If that owner is the sole requester, it is re-granted. The result is back-to-back beats with no idle gap.
- **Dropped request.** If req[i] drops while gnt[i] = 1, no beat occurs in that cycle: fields are 0 and enables are 0.

## Timing
- **Reset values.**
  - gnt = 0, owner = 0, timeout = 0, hold_cnt = 0, rr_ptr = 0.
  - All bus outputs are 0 and both enables are 0.
  - Requester 0 has first priority after reset.
- **Grant latency.** req[i] rises before edge n → gnt[i] = 1 after edge n → first beat in cycle n+1.
- **Handover.** There are no idle cycles between owners when others are waiting. The last beat of the old owner is followed directly by the first beat of the new owner.
- **Bus outputs.** Combinational from gnt, req and cmd. Requesters must hold cmd stable for the whole cycle.
- **Reset mid-grant.** Asserting reset clears gnt and the enables immediately (asynchronously). An in-flight beat is abandoned and no decoder enable glitches high.
- **Simultaneous events.** If req and lock change in the same cycle as a forced release, the release wins and the masked owner cannot win that arbitration.

## Structure
- **Shared package cpu_bus_pkg** holds:
  - MID_W = 5, SID_W = 5, AMID_W = 2, CMD_W = 12.
  - MID/SID code constants: IR0 = 0, A = 2, B = 3, MEM = 4, SR = 17, ALU = 18.
  - AMID codes: PC = 0, AR = 1, SP = 2, R0R1 = 3.
- **Sub-module rr_pick.** A combinational round-robin priority picker.
  - Inputs: req vector and start pointer.
  - Outputs: one-hot winner and a valid flag.
  - Instantiated once.
- The remaining FSM, counter and output mux live in cpu_bus_arbiter.

## Test plan
- **Single requester.** Reset, then req = 4'b0100 with cmd[2] = {mid 4, sid 2, amid 0} → gnt = 4'b0100 one cycle later. bus_mid = 4, bus_sid = 2, mid_en = sid_en = 1 every cycle.
- **Two-way alternation.** req = 4'b0101, lock = 0 → gnt sequence 0001, 0100, 0001, 0100 with no IDLE cycles.
- **Lock timeout.** Requester 1 locked continuously with req = 4'b0011 and MAX_HOLD = 8 → exactly 8 consecutive beats on 1, then timeout = 1 for one cycle, then gnt = 0001.
- **Early release.** Requester 3 locked; drop lock after beat 3 with req = 4'b1001 → grant moves to 0 after 3 beats and timeout stays 0.
- **Reset mid-grant.** Assert reset while gnt = 0010 → gnt, mid_en and sid_en go to 0 before the next edge. After release, gnt = 0001 if req[0] is set.
- **Full round-robin.** req = 4'b1111, lock = 0 → gnt cycles 0001, 0010, 0100, 1000, 0001, with owner = 0, 1, 2, 3, 0.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg: shared field widths, decoder codes and command layout for the CPU bus arbiter
package cpu_bus_pkg;
    localparam int MID_W  = 5;
    localparam int SID_W  = 5;
    localparam int AMID_W = 2;
    localparam int CMD_W  = MID_W + SID_W + AMID_W;

    localparam logic [MID_W-1:0] CODE_IR0 = 5'd0;
    localparam logic [MID_W-1:0] CODE_A   = 5'd2;
    localparam logic [MID_W-1:0] CODE_B   = 5'd3;
    localparam logic [MID_W-1:0] CODE_MEM = 5'd4;
    localparam logic [MID_W-1:0] CODE_SR  = 5'd17;
    localparam logic [MID_W-1:0] CODE_ALU = 5'd18;

    typedef enum logic [AMID_W-1:0] {
        AMID_PC   = 2'd0,
        AMID_AR   = 2'd1,
        AMID_SP   = 2'd2,
        AMID_R0R1 = 2'd3
    } amid_e;

    typedef struct packed {
        logic [MID_W-1:0] mid;
        logic [SID_W-1:0] sid;
        amid_e            amid;
    } cmd_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first set request at or after start with wrap-around
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] start_i,
    output logic [N-1:0]  win_o,
    output logic          valid_o
);
    logic [PW-1:0] idx;

    // scan offsets from farthest to nearest so the nearest set request overwrites the others
    always_comb begin
        win_o = '0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = PW'((int'(start_i) + k) % N);
            if (req_i[idx]) win_o = N'(1) << idx;
        end
        valid_o = |req_i;
    end
endmodule

// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter: round-robin owner of the MID/SID/AMID bus fields with bounded locked bursts
module cpu_bus_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NREQ-1:0]       req_i,
    input  logic [NREQ-1:0]       lock_i,
    input  logic [NREQ*CMD_W-1:0] cmd_i,
    output logic [NREQ-1:0]       gnt_o,
    output logic [MID_W-1:0]      bus_mid_o,
    output logic [SID_W-1:0]      bus_sid_o,
    output logic [AMID_W-1:0]     bus_amid_o,
    output logic                  mid_en_o,
    output logic                  sid_en_o,
    output logic [2:0]            owner_o,
    output logic                  timeout_o
);
    localparam int PW = $clog2(NREQ);
    localparam int HW = $clog2(MAX_HOLD) + 1;

    logic [NREQ-1:0] gnt_q, gnt_d, cand, win;
    logic [HW-1:0]   hold_q, hold_d;
    logic [PW-1:0]   rr_q, rr_d, own, win_idx;
    logic            tmo_q, tmo_d;
    logic            win_v, owner_locked, keep, force_rel, beat;
    cmd_t            cmds [NREQ];
    cmd_t            cmd_sel;

    for (genvar g = 0; g < NREQ; g++) begin : g_cmd
        assign cmds[g] = cmd_i[g*CMD_W +: CMD_W];
    end

    rr_pick #(.N(NREQ), .PW(PW)) u_pick (
        .req_i   (cand),
        .start_i (rr_q),
        .win_o   (win),
        .valid_o (win_v)
    );

    // one-hot to index for the current owner and the arbitration winner
    always_comb begin
        own     = '0;
        win_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt_q[k]) own = PW'(k);
            if (win[k]) win_idx = PW'(k);
        end
    end

    // state register: grant, burst counter, round-robin pointer and timeout pulse
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gnt_q  <= '0;
            hold_q <= '0;
            rr_q   <= '0;
            tmo_q  <= 1'b0;
        end else begin
            gnt_q  <= gnt_d;
            hold_q <= hold_d;
            rr_q   <= rr_d;
            tmo_q  <= tmo_d;
        end
    end

    // next state: keep a locked owner until its last allowed beat, otherwise re-arbitrate
    always_comb begin
        owner_locked = (|gnt_q) && req_i[own] && lock_i[own];
        keep         = owner_locked && (hold_q < HW'(MAX_HOLD - 1));
        force_rel    = owner_locked && !keep;
        cand         = force_rel ? (req_i & ~gnt_q) : req_i;
        gnt_d        = keep ? gnt_q : (win_v ? win : '0);
        hold_d       = keep ? hold_q + 1'b1 : '0;
        rr_d         = (!keep && win_v) ? ((win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1) : rr_q;
        tmo_d        = force_rel;
    end

    // outputs: the granted command drives the decoders only while its request is still up
    always_comb begin
        beat       = |(gnt_q & req_i);
        cmd_sel    = beat ? cmds[own] : '0;
        gnt_o      = gnt_q;
        bus_mid_o  = cmd_sel.mid;
        bus_sid_o  = cmd_sel.sid;
        bus_amid_o = cmd_sel.amid;
        mid_en_o   = beat;
        sid_en_o   = beat;
        owner_o    = 3'(own);
        timeout_o  = tmo_q;
    end
endmodule
